bitblt_row_addr_gen: RTL and testbench

//   Front end of the bitblt datapath. Walks a rectangle row by row and issues one

---
 rtl/bitblt_pkg.sv | 20 ++
 rtl/bitblt_row_mul_reg.sv | 21 ++
 rtl/bitblt_row_addr_gen.sv | 110 +++++++++++
 tb/tb_bitblt_row_addr_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitblt_pkg.sv
// Shared widths and FSM encoding for the bitblt row address generator.
// Keeps the operand widths of the row-offset multiply in one place.
package bitblt_pkg;

    localparam int ADDR_W         = 32;
    localparam int ROW_W          = 17;
    localparam int STRIDE_W       = 19;
    localparam int COL_W          = 16;
    localparam int PIX_BYTES_LOG2 = 2;
    localparam int PROD_W         = ROW_W + STRIDE_W;
    localparam int LEN_W          = COL_W + PIX_BYTES_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bitblt_row_mul_reg.sv
// Registered unsigned row x stride multiply; the product only updates when en is high.
module bitblt_row_mul_reg
    import bitblt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [ROW_W-1:0]    a,
    input  logic [STRIDE_W-1:0] b,
    output logic [PROD_W-1:0]   prod
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
        end else if (en) begin
            prod <= PROD_W'(a) * PROD_W'(b);
        end
    end

endmodule

// File: rtl/bitblt_row_addr_gen.sv
// Walks a rectangle row by row and issues one burst request (address, byte length) per row.
// The row offset comes from a one-cycle registered multiply, so each row costs CALC + ISSUE.
module bitblt_row_addr_gen
    import bitblt_pkg::*;
(
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [COL_W-1:0]    cfg_x,
    input  logic [ROW_W-1:0]    cfg_y,
    input  logic [COL_W-1:0]    cfg_w,
    input  logic [ROW_W-1:0]    cfg_h,
    output logic                busy,
    output logic                done,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [LEN_W-1:0]    req_len
);

    state_t                state;
    logic [ADDR_W-1:0]     base_x_q;
    logic [STRIDE_W-1:0]   stride_q;
    logic [ROW_W-1:0]      y_q;
    logic [ROW_W-1:0]      h_q;
    logic [ROW_W-1:0]      row_q;
    logic [ROW_W-1:0]      mul_row;
    logic [PROD_W-1:0]     prod;
    logic                  last_row;
    logic                  unused_prod_hi;

    // Row index wraps in ROW_W bits before it reaches the multiplier.
    assign mul_row  = y_q + row_q;
    assign last_row = (row_q == h_q - ROW_W'(1));

    bitblt_row_mul_reg u_mul (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .en    (state == ST_CALC),
        .a     (mul_row),
        .b     (stride_q),
        .prod  (prod)
    );

    // Base and column offset are pre-summed at start; the product only changes in CALC,
    // so the address is stable for the whole ISSUE phase and reads 0 after reset.
    assign req_addr       = base_x_q + prod[ADDR_W-1:0];
    assign unused_prod_hi = ^prod[PROD_W-1:ADDR_W];

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_valid <= 1'b0;
            req_len   <= '0;
            base_x_q  <= '0;
            stride_q  <= '0;
            y_q       <= '0;
            h_q       <= '0;
            row_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_x_q <= cfg_base + (ADDR_W'(cfg_x) << PIX_BYTES_LOG2);
                        stride_q <= cfg_stride;
                        y_q      <= cfg_y;
                        h_q      <= cfg_h;
                        row_q    <= '0;
                        req_len  <= {cfg_w, {PIX_BYTES_LOG2{1'b0}}};
                        busy     <= 1'b1;
                        state    <= (cfg_w == '0 || cfg_h == '0) ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    req_valid <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (last_row) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            row_q <= row_q + ROW_W'(1);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    // Reached with done already high after the last row; an empty
                    // rectangle arrives here still busy and raises done on the way out.
                    done  <= busy;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitblt_row_addr_gen.sv
// Randomized bench for bitblt_row_addr_gen: a row-list model predicts every request,
// busy/done window and valid timing, checked each cycle on the falling edge.
module tb_bitblt_row_addr_gen;
    import bitblt_pkg::*;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   cfg_base = '0;
    logic [STRIDE_W-1:0] cfg_stride = '0;
    logic [COL_W-1:0]    cfg_x = '0;
    logic [ROW_W-1:0]    cfg_y = '0;
    logic [COL_W-1:0]    cfg_w = '0;
    logic [ROW_W-1:0]    cfg_h = '0;
    logic                busy;
    logic                done;
    logic                req_valid;
    logic                req_ready = 1'b0;
    logic [ADDR_W-1:0]   req_addr;
    logic [LEN_W-1:0]    req_len;

    always #5 ap_clk = ~ap_clk;

    bitblt_row_addr_gen dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .start      (start),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .busy       (busy),
        .done       (done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [17:0] len;
    } row_t;

    row_t        exp_q[$];
    logic [31:0] hs_log[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_from = 1;
    int busy_to = 0;
    int done_at = -1;
    int valid_from = 0;
    int rmode = 0;   // 0: ready always 1, 1: random ready, 2: driven by hand

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [18:0] stride,
                                               input logic [15:0] x, input logic [16:0] y,
                                               input int row);
        longint      yy;
        logic [63:0] t;
        yy = (longint'(y) + row) % 131072;
        t  = 64'(longint'(base) + yy * longint'(stride) + longint'(x) * 4);
        return t[31:0];
    endfunction

    // Compare process: outputs of cycle cyc checked against the row-list model.
    initial begin
        row_t e;
        bit   busy_e;
        bit   valid_e;
        forever begin
            @(negedge ap_clk);
            cyc++;
            if (!ap_rst_n) begin
                check("reset_outputs", {busy, done, req_valid, req_addr, req_len}, 64'd0);
                exp_q.delete();
                busy_from = 1;
                busy_to   = 0;
                done_at   = -1;
            end else begin
                busy_e  = (cyc >= busy_from) && (cyc <= busy_to);
                valid_e = (exp_q.size() > 0) && (cyc >= valid_from);
                check("busy", busy, busy_e);
                check("done", done, cyc == done_at);
                check("req_valid", req_valid, valid_e);
                if (req_valid && valid_e) begin
                    check("req_addr", req_addr, exp_q[0].addr);
                    check("req_len", req_len, exp_q[0].len);
                    if (req_ready) begin
                        hs_log.push_back(req_addr);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            busy_to = cyc;
                            done_at = cyc + 1;
                        end else begin
                            valid_from = cyc + 2;
                        end
                    end
                end
                if (start && !busy_e) begin
                    busy_from = cyc + 1;
                    if (cfg_w == 0 || cfg_h == 0) begin
                        busy_to = cyc + 1;
                        done_at = cyc + 2;
                    end else begin
                        busy_to    = 1 << 30;
                        valid_from = cyc + 2;
                        for (int r = 0; r < int'(cfg_h); r++) begin
                            e.addr = model_addr(cfg_base, cfg_stride, cfg_x, cfg_y, r);
                            e.len  = 18'(int'(cfg_w) * 4);
                            exp_q.push_back(e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
        case (rmode)
            0: req_ready = 1'b1;
            1: req_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [18:0] s, input logic [15:0] x,
                               input logic [16:0] y, input logic [15:0] w, input logic [16:0] h);
        cfg_base   = b;
        cfg_stride = s;
        cfg_x      = x;
        cfg_y      = y;
        cfg_w      = w;
        cfg_h      = h;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        cfg_base   = $urandom;
        cfg_stride = 19'($urandom);
        cfg_x      = 16'($urandom);
        cfg_y      = 17'($urandom);
        cfg_w      = 16'($urandom);
        cfg_h      = 17'($urandom);
    endtask

    // Waits for done, then one more cycle so the FSM is back in IDLE.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check({name, "_done_seen"}, seen, 1'b1);
        tick();
    endtask

    initial begin
        int b;
        bit ok;
        logic [15:0] w;
        logic [16:0] h;

        #1;
        check("reset_state", {busy, done, req_valid, req_addr, req_len}, 64'd0);
        repeat (3) tick();
        ap_rst_n = 1'b1;
        repeat (2) tick();

        // Model pinned against hand-computed addresses.
        check("model_t1_r0", model_addr(32'h1000_0000, 19'd2560, 16'd10, 17'd5, 0), 32'h1000_3228);
        check("model_t1_r2", model_addr(32'h1000_0000, 19'd2560, 16'd10, 17'd5, 2), 32'h1000_4628);
        check("model_wrap_addr", model_addr(32'hFFFF_F000, 19'h2000, 16'd0, 17'd1, 0), 32'h0000_1000);
        check("model_wrap_row", model_addr(32'h0, 19'd4, 16'd0, 17'h1FFFF, 1), 32'h0);

        // Basic three-row rectangle, ready always high.
        rmode = 0;
        b = hs_log.size();
        pulse_start(32'h1000_0000, 19'd2560, 16'd10, 17'd5, 16'd4, 17'd3);
        wait_done("t1");
        check("t1_rows", hs_log.size() - b, 3);
        if (hs_log.size() == b + 3) begin
            check("t1_addr0", hs_log[b], 32'h1000_3228);
            check("t1_addr1", hs_log[b+1], 32'h1000_3C28);
            check("t1_addr2", hs_log[b+2], 32'h1000_4628);
        end

        // Backpressure on row 1 for five cycles.
        rmode = 2;
        req_ready = 1'b1;
        b = hs_log.size();
        pulse_start(32'h1000_0000, 19'd2560, 16'd10, 17'd5, 16'd4, 17'd3);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (hs_log.size() == b + 1) ok = 1'b1;
            else tick();
        end
        check("t2_first_hs", ok, 1'b1);
        req_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_valid) ok = 1'b1;
            else tick();
        end
        check("t2_valid_seen", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", req_valid, 1'b1);
            check("t2_hold_addr", req_addr, 32'h1000_3C28);
            tick();
        end
        rmode = 0;
        wait_done("t2");
        check("t2_rows", hs_log.size() - b, 3);

        // Empty rectangles: zero height, then zero width.
        b = hs_log.size();
        pulse_start(32'h2000_0000, 19'd64, 16'd1, 17'd1, 16'd4, 17'd0);
        wait_done("t3_h0");
        pulse_start(32'h2000_0000, 19'd64, 16'd1, 17'd1, 16'd0, 17'd3);
        wait_done("t3_w0");
        check("t3_no_rows", hs_log.size() - b, 0);

        // Address wraps modulo 2^32.
        b = hs_log.size();
        pulse_start(32'hFFFF_F000, 19'h2000, 16'd0, 17'd1, 16'd1, 17'd1);
        wait_done("t4");
        check("t4_rows", hs_log.size() - b, 1);
        if (hs_log.size() == b + 1) check("t4_addr", hs_log[b], 32'h0000_1000);

        // Row index wraps in 17 bits.
        b = hs_log.size();
        pulse_start(32'h0, 19'd4, 16'd0, 17'h1FFFF, 16'd2, 17'd2);
        wait_done("t5");
        check("t5_rows", hs_log.size() - b, 2);
        if (hs_log.size() == b + 2) begin
            check("t5_addr0", hs_log[b], 32'h0007_FFFC);
            check("t5_addr1", hs_log[b+1], 32'h0000_0000);
        end

        // Asynchronous reset while a request is pending.
        rmode = 2;
        req_ready = 1'b0;
        pulse_start(32'h3000_0000, 19'd128, 16'd2, 17'd7, 16'd3, 17'd4);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_valid) ok = 1'b1;
            else tick();
        end
        check("t6_valid_seen", ok, 1'b1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("t6_async_clear", {busy, done, req_valid, req_addr, req_len}, 64'd0);
        repeat (2) tick();
        ap_rst_n = 1'b1;
        tick();
        check("t6_idle_busy", busy, 1'b0);
        check("t6_no_done", done, 1'b0);

        // Fresh run after reset, with a second start issued while busy.
        rmode = 0;
        b = hs_log.size();
        pulse_start(32'h4000_0100, 19'd1024, 16'd3, 17'd2, 16'd5, 17'd4);
        pulse_start(32'h5555_0000, 19'd8, 16'd9, 17'd9, 16'd1, 17'd1);
        wait_done("t6_rerun");
        check("t6_rows", hs_log.size() - b, 4);
        if (hs_log.size() == b + 4) check("t6_addr0", hs_log[b], 32'h4000_090C);

        // Randomized rectangles with random backpressure.
        rmode = 1;
        for (int j = 0; j < 40; j++) begin
            w = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 16));
            h = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom_range(1, 5));
            pulse_start($urandom, 19'($urandom),  16'($urandom),
                        ($urandom_range(0, 3) == 0) ? 17'h1FFFE : 17'($urandom), w, h);
            if (w != 0 && h >= 2 && $urandom_range(0, 1) == 1)
                pulse_start($urandom, 19'($urandom), 16'($urandom), 17'($urandom), 16'd2, 17'd2);
            wait_done("rand");
        end
        rmode = 0;
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
